// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    // Scan sequencer states: all digits dark, or one digit lit.
    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } scan_state_t;

    // Active-low segment drive with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to active-low seven-segment decoder.
// Bit order: bit 0 = a, 1 = b, 2 = c, 3 = d, 4 = e, 5 = f, 6 = g.
module seven_segment (
    input  logic [3:0] nibble,
    output logic [6:0] segments_n
);

    // Pure lookup; a 0 in a bit position lights that segment.
    always_comb begin
        segments_n = 7'h7F;
        unique case (nibble)
            4'h0: segments_n = 7'h40;
            4'h1: segments_n = 7'h79;
            4'h2: segments_n = 7'h24;
            4'h3: segments_n = 7'h30;
            4'h4: segments_n = 7'h19;
            4'h5: segments_n = 7'h12;
            4'h6: segments_n = 7'h02;
            4'h7: segments_n = 7'h78;
            4'h8: segments_n = 7'h00;
            4'h9: segments_n = 7'h10;
            4'hA: segments_n = 7'h08;
            4'hB: segments_n = 7'h03;
            4'hC: segments_n = 7'h46;
            4'hD: segments_n = 7'h21;
            4'hE: segments_n = 7'h06;
            4'hF: segments_n = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display scanner with tear-free value loading.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN: auto-blank leading zero digits (never digit 0).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_start
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    // A single gap cycle still needs a 1-bit counter to keep the types legal.
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    scan_state_t             state_q, state_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_W-1:0]       disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
    logic [DATA_W-1:0]       pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    load_ready_q, load_ready_d;
    logic [6:0]              segments_q, segments_d;
    logic [NUM_DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
    logic                    frame_start_q, frame_start_d;

    logic                    frame_edge;
    logic [NUM_DIGITS-1:0]   blank_eff;
    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic                    zero_above;
`endif

    // Scan sequencer: GAP for GAP_CYCLES, ON for SCAN_DIV, advance digit on leaving ON.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        case (state_q)
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ON;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ON: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    state_d    = GAP;
                    scan_cnt_d = '0;
                    idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            default: state_d = GAP;
        endcase
    end

    // Start of a new frame: digit 0 about to be lit.
    assign frame_edge = (state_q == GAP) && (state_d == ON) && (idx_d == '0);

    // Load handshake: capture into pending, swap into display only at a frame boundary.
    always_comb begin
        pend_d       = pend_q;
        pend_blank_d = pend_blank_q;
        disp_d       = disp_q;
        disp_blank_d = disp_blank_q;
        load_ready_d = load_ready_q;
        if (load_valid && load_ready_q) begin
            pend_d       = load_value;
            pend_blank_d = blank_mask;
            load_ready_d = 1'b0;
        end
        // load_ready low means pending holds a value not yet shown.
        if (frame_edge && !load_ready_q) begin
            disp_d       = pend_q;
            disp_blank_d = pend_blank_q;
            load_ready_d = 1'b1;
        end
    end

    // Effective blanking: explicit mask, optionally plus leading-zero suppression.
    always_comb begin
        blank_eff = disp_blank_d;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_above   = zero_above & (disp_d[4*i +: 4] == 4'h0);
            blank_eff[i] = blank_eff[i] | zero_above;
        end
`endif
    end

    assign cur_nibble = disp_d[{idx_d, 2'b00} +: 4];

    seven_segment u_dec (
        .nibble     (cur_nibble),
        .segments_n (dec_seg)
    );

    // Outputs computed from next state so segments and digit select flip on the same edge.
    always_comb begin
        segments_d   = SEG_OFF;
        digit_en_n_d = '1;
        if (state_d == ON) begin
            digit_en_n_d[idx_d] = 1'b0;
            if (!blank_eff[idx_d]) begin
                segments_d = dec_seg;
            end
        end
        frame_start_d = frame_edge;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= GAP;
            gap_cnt_q     <= '0;
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            disp_q        <= '0;
            disp_blank_q  <= '0;
            pend_q        <= '0;
            pend_blank_q  <= '0;
            load_ready_q  <= 1'b1;
            segments_q    <= SEG_OFF;
            digit_en_n_q  <= '1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            disp_q        <= disp_d;
            disp_blank_q  <= disp_blank_d;
            pend_q        <= pend_d;
            pend_blank_q  <= pend_blank_d;
            load_ready_q  <= load_ready_d;
            segments_q    <= segments_d;
            digit_en_n_q  <= digit_en_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign segments    = segments_q;
    assign digit_en_n  = digit_en_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, GAP_CYCLES=1).
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int GC = 1;

    logic          clk;
    logic          reset_n;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_value;
    logic [3:0]    blank_mask;
    logic [6:0]    segments;
    logic [3:0]    digit_en_n;
    logic          frame_start;

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GAP_CYCLES (GC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .blank_mask  (blank_mask),
        .segments    (segments),
        .digit_en_n  (digit_en_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    // Queue the four lit phases one frame of this value should produce.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] m);
        exp_t e;
        logic b;
        for (int i = 0; i < ND; i++) begin
            b = m[i];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            if (i >= 1 && (v >> (4 * i)) == 16'h0) b = 1'b1;
`endif
            e.en  = ~(4'b0001 << i);
            e.seg = b ? 7'h7F : seg_of(v[4*i +: 4]);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) check_eq("frame_timeout", frame_start, 1);
    endtask

    task automatic wait_en(input logic [3:0] en);
        int n = 0;
        @(negedge clk);
        while (digit_en_n !== en && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (digit_en_n !== en) check_eq("digit_timeout", digit_en_n, en);
    endtask

    // Called at a negedge; the following posedge accepts the offer.
    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        check_eq("ready_before_load", load_ready, 1);
        load_value = v;
        blank_mask = m;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check_eq("ready_after_load", load_ready, 0);
    endtask

    // Monitor: each lit phase pops one expectation; gap and phase lengths are timed.
    initial begin
        int   off_run = 0;
        int   phase_len = 0;
        bit   in_phase = 0;
        logic [3:0] cur_en = '1;
        logic [6:0] cur_seg = '1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                off_run   = 0;
                phase_len = 0;
                in_phase  = 0;
            end else if (digit_en_n !== 4'hF) begin
                if (!in_phase || digit_en_n !== cur_en) begin
                    if (in_phase) check_eq("phase_len", phase_len, SD);
                    check_eq("gap_len", off_run, GC);
                    if (sb_q.size() == 0) begin
                        check_eq("sb_empty", digit_en_n, 4'hF);
                        cur_seg = segments;
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("digit_en_n", digit_en_n, e.en);
                        check_eq("segments", segments, e.seg);
                        cur_seg = e.seg;
                    end
                    check_eq("frame_start_first", frame_start, digit_en_n == 4'b1110);
                    cur_en    = digit_en_n;
                    phase_len = 1;
                    in_phase  = 1;
                end else begin
                    phase_len++;
                    check_eq("seg_stable", segments, cur_seg);
                    check_eq("frame_start_once", frame_start, 0);
                end
                off_run = 0;
            end else begin
                if (in_phase) check_eq("phase_len", phase_len, SD);
                in_phase = 0;
                off_run++;
                check_eq("gap_segments", segments, 7'h7F);
                check_eq("gap_frame_start", frame_start, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b1;
        load_valid = 1'b0;
        load_value = '0;
        blank_mask = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_segments", segments, 7'h7F);
        check_eq("rst_digit_en_n", digit_en_n, 4'hF);
        check_eq("rst_load_ready", load_ready, 1);
        check_eq("rst_frame_start", frame_start, 0);

        push_frame(16'h0000, 4'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        wait_frame();                       // frame 1: reset contents
        do_load(16'h1234, 4'h0);
        push_frame(16'h1234, 4'h0);

        wait_frame();                       // frame 2: 1234
        do_load(16'hAAAA, 4'h0);
        push_frame(16'hAAAA, 4'h0);
        // Offer while busy must be dropped.
        load_value = 16'h5555;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check_eq("ready_busy", load_ready, 0);

        wait_frame();                       // frame 3: AAAA
        check_eq("ready_reassert", load_ready, 1);
        do_load(16'h8888, 4'b0100);
        push_frame(16'h8888, 4'b0100);

        wait_frame();                       // frame 4: 8888 with digit 2 masked
        do_load(16'h0005, 4'h0);
        push_frame(16'h0005, 4'h0);

        wait_frame();                       // frame 5: 0005
        wait_en(4'b1011);
        load_value = 16'hFFFF;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check_eq("ready_pending", load_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_segments", segments, 7'h7F);
        check_eq("mid_rst_digit_en_n", digit_en_n, 4'hF);
        check_eq("mid_rst_load_ready", load_ready, 1);
        check_eq("mid_rst_frame_start", frame_start, 0);
        sb_q.delete();
        push_frame(16'h0000, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;

        wait_frame();                       // frame 6: pending value was discarded
        check_eq("post_rst_ready", load_ready, 1);
        push_frame(16'h0000, 4'h0);
        wait_frame();                       // frame 7
        repeat (19) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is lit (>=2).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, all-digits-off cycles between digits (>=1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port load_valid, input, 1, new display value offered.
REQ-007 SHALL have port load_ready, output, 1, block can accept a value.
REQ-008 SHALL have port load_value, input, 4*NUM_DIGITS, nibble i is the hex digit for digit i; digit 0 is least significant.
REQ-009 SHALL have port blank_mask, input, NUM_DIGITS, bit i=1 forces digit i dark; sampled with load_value.
REQ-010 SHALL have port segments, output, 7, active-low segment drive, bit order as the seven_segment decoder.
REQ-011 SHALL have port digit_en_n, output, NUM_DIGITS, active-low one-hot digit select.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse when digit 0 is lit.

Function
REQ-013 SHALL implement FSM states GAP and ON; GAP holds digit_en_n all-ones and segments 7'h7F for GAP_CYCLES cycles, then enters ON.
REQ-014 SHALL hold ON for exactly SCAN_DIV cycles with digit_en_n bit idx low, then enter GAP and advance idx; idx wraps NUM_DIGITS-1 -> 0.
REQ-015 SHALL register segments and digit_en_n, both changing on the same edge; no output glitch between digits.
REQ-016 SHALL accept a load on any cycle with load_valid && load_ready into a pending register and deassert load_ready the next cycle.
REQ-017 SHALL transfer pending into the display register at the GAP->ON transition with idx==0 only (tear-free frame), and reassert load_ready the following cycle.
REQ-018 SHALL, for load_valid with load_ready low, ignore the value; the requester holds load_valid until accepted.
REQ-019 SHALL drive segments 7'h7F while ON for a digit whose display blank bit is set.
REQ-020 SHALL pulse frame_start for exactly the first ON cycle of digit 0.
REQ-021 SHALL size counters as $clog2 of their limits; no counter exceeds its limit minus one.

Reset
REQ-022 SHALL on reset_n low immediately set: state GAP, gap/scan counters 0, idx 0, display and pending registers 0, blank bits 0, load_ready 1, segments 7'h7F, digit_en_n all-ones, frame_start 0.
REQ-023 SHALL, when reset is asserted mid-frame or mid-load, discard the pending value; first ON after release is digit 0 after GAP_CYCLES.

Configuration
REQ-024 SHALL support macro SEG_SCAN_LEADING_ZERO_BLANK_EN.
REQ-025 SHALL with the macro defined also blank digit i (i>=1) when its nibble and all more-significant nibbles are zero; digit 0 never auto-blanked.
REQ-026 SHALL without the macro display every non-masked digit, zeros included.

Structure
REQ-027 SHALL place state enum scan_state_t {GAP, ON} and constant SEG_OFF = 7'h7F in shared package seg_pkg.
REQ-028 SHALL instantiate exactly one seven_segment decoder, fed by the display nibble selected by idx, as its sole sub-module.

Verification (NUM_DIGITS=4, SCAN_DIV=4, GAP_CYCLES=1)
REQ-029 SHALL check reset: release reset_n -> 1 cycle all-off, then digit_en_n=4'b1110 for 4 cycles, frame_start high on its first cycle only; segments show 0.
REQ-030 SHALL check scan: load 16'h1234 -> digit_en_n sequence 1110,1111,1101,1111,1011,1111,0111, each lit 4 cycles; segments decode 4,3,2,1.
REQ-031 SHALL check handshake: load 16'hAAAA mid-frame -> load_ready low next cycle; display changes only at next digit-0 ON; second load_valid while pending ignored.
REQ-032 SHALL check blanking: blank_mask=4'b0100 with 16'h8888 -> digit 2 lit with segments 7'h7F, others show 8.
REQ-033 SHALL check macro: 16'h0005 -> with SEG_SCAN_LEADING_ZERO_BLANK_EN digits 3..1 dark, digit 0 shows 5; without, all four digits shown.
REQ-034 SHALL check reset mid-ON of digit 2 with pending value -> outputs off immediately, pending lost, load_ready 1.
